// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the IF/D memory arbiter: FSM states, read-owner codes
// and data-path widths.
package mem_arbiter_pkg;

    localparam int WORD_W = 32;
    localparam int BE_W   = WORD_W / 8;

    typedef enum logic {
        ST_IDLE,
        ST_RMW_WR
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_IF,
        OWN_D
    } owner_t;

endpackage

// File: rtl/mem_arbiter_store_merge.sv
// Combinational byte-lane merge: each lane takes wdata where its enable is set,
// otherwise it keeps the word's current contents.
module store_merge
    import mem_arbiter_pkg::*;
(
    input  logic [BE_W-1:0]   be,
    input  logic [WORD_W-1:0] wdata,
    input  logic [WORD_W-1:0] rdata,
    output logic [WORD_W-1:0] merged
);

    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        assign merged[8*i +: 8] = be[i] ? wdata[8*i +: 8] : rdata[8*i +: 8];
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates the single-port MemoryUnit between instruction fetch and the data
// port; sub-word stores run as a read followed by a merged full-word write.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W      = 10,
    parameter int MAX_DSTREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [31:0]       d_rdata,
    output logic              d_wack,
    output logic [31:0]       mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_write,
    input  logic [31:0]       mem_rdata
);

    localparam int              SW         = $clog2(MAX_DSTREAK + 1);
    localparam logic [SW-1:0]   STREAK_MAX = SW'(MAX_DSTREAK);

    state_t              state, state_nxt;
    owner_t              rd_owner, rd_owner_nxt;
    logic [SW-1:0]       streak, streak_nxt;
    logic                live;
    logic                active;
    logic                wack_q, wack_nxt;
    logic                cap_en;
    logic [ADDR_W-1:0]   cap_idx;
    logic [31:0]         cap_wdata;
    logic [3:0]          cap_be;
    logic [ADDR_W-1:0]   idx;
    logic [ADDR_W-1:0]   if_idx, d_idx;
    logic [31:0]         merged;
    logic                unused_addr_bits;

    // live holds outputs quiet for the first cycle after reset is released.
    assign active = !rst && live;
    assign if_idx = if_addr[ADDR_W+1:2];
    assign d_idx  = d_addr[ADDR_W+1:2];
    assign unused_addr_bits = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                                d_addr[31:ADDR_W+2], d_addr[1:0]};

    store_merge u_merge (
        .be     (cap_be),
        .wdata  (cap_wdata),
        .rdata  (mem_rdata),
        .merged (merged)
    );

    always_comb begin
        state_nxt    = state;
        rd_owner_nxt = OWN_NONE;
        wack_nxt     = 1'b0;
        if_gnt       = 1'b0;
        d_gnt        = 1'b0;
        mem_write    = 1'b0;
        mem_wdata    = '0;
        idx          = '0;
        cap_en       = 1'b0;
        if (active) begin
            case (state)
                ST_IDLE: begin
                    if (d_req && !(if_req && streak == STREAK_MAX)) d_gnt = 1'b1;
                    else if (if_req)                                 if_gnt = 1'b1;
                    if (if_gnt) begin
                        idx          = if_idx;
                        rd_owner_nxt = OWN_IF;
                    end else if (d_gnt) begin
                        idx = d_idx;
                        if (!d_we) begin
                            rd_owner_nxt = OWN_D;
                        end else if (d_be == 4'hF) begin
                            mem_write = 1'b1;
                            mem_wdata = d_wdata;
                            wack_nxt  = 1'b1;
                        end else if (d_be == 4'h0) begin
                            wack_nxt  = 1'b1;
                        end else begin
                            // Read the old word now; merge and write it next cycle.
                            cap_en    = 1'b1;
                            state_nxt = ST_RMW_WR;
                        end
                    end
                end
                ST_RMW_WR: begin
                    mem_write = 1'b1;
                    mem_wdata = merged;
                    idx       = cap_idx;
                    wack_nxt  = 1'b1;
                    state_nxt = ST_IDLE;
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        streak_nxt = streak;
        if (!if_req || if_gnt)                  streak_nxt = '0;
        else if (d_gnt && streak != STREAK_MAX) streak_nxt = streak + 1'b1;
    end

    assign mem_addr  = {{(32-ADDR_W){1'b0}}, idx};
    assign if_rvalid = active && rd_owner == OWN_IF;
    assign d_rvalid  = active && rd_owner == OWN_D;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign d_rdata   = d_rvalid  ? mem_rdata : '0;
    assign d_wack    = active && wack_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            rd_owner  <= OWN_NONE;
            streak    <= '0;
            wack_q    <= 1'b0;
            live      <= 1'b0;
            cap_idx   <= '0;
            cap_wdata <= '0;
            cap_be    <= '0;
        end else begin
            state    <= state_nxt;
            rd_owner <= rd_owner_nxt;
            streak   <= streak_nxt;
            wack_q   <= wack_nxt;
            live     <= 1'b1;
            if (cap_en) begin
                cap_idx   <= d_idx;
                cap_wdata <= d_wdata;
                cap_be    <= d_be;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: behavioural MemoryUnit, transaction-level reference
// model, directed scenarios followed by randomized traffic.
module tb_mem_arbiter;

    localparam int MAXD  = 4;
    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_wack;
    logic [3:0]  d_be;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_write;

    mem_arbiter #(.ADDR_W(10), .MAX_DSTREAK(MAXD)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_wack(d_wack),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // MemoryUnit: registered data_out, held during write cycles.
    logic [31:0] mem [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
        else           mem_rdata <= mem[mem_addr[9:0]];
    end

    // Reference model state (transaction level)
    logic [31:0] ref_mem [0:DEPTH-1];
    int          streak, rmw_idx;
    bit          live, in_rmw, e_if_rv, e_d_rv, e_wack;
    logic [31:0] e_rdata, rmw_val;
    int          checks, errors;
    logic        o_if_gnt, o_d_gnt, o_wack, o_mem_write;
    logic [31:0] o_mem_addr;

    function automatic int widx(input logic [31:0] a);
        return int'((a / 32'd4) % DEPTH);
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = $urandom & 32'hFFFF_F003;
        return a | (32'($urandom_range(0, 15)) << 2);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: inputs are already driven; check at #1, advance to next negedge.
    task automatic cycle();
        bit gi, gd, n_if, n_d, n_wack, n_rmw;
        logic [31:0] n_rdata;
        #1;
        o_if_gnt = if_gnt; o_d_gnt = d_gnt; o_wack = d_wack;
        o_mem_write = mem_write; o_mem_addr = mem_addr;
        if (rst) begin
            chk("rst_if_gnt", 32'(if_gnt), 0);     chk("rst_d_gnt", 32'(d_gnt), 0);
            chk("rst_if_rvalid", 32'(if_rvalid), 0); chk("rst_d_rvalid", 32'(d_rvalid), 0);
            chk("rst_if_rdata", if_rdata, 0);      chk("rst_d_rdata", d_rdata, 0);
            chk("rst_d_wack", 32'(d_wack), 0);     chk("rst_mem_write", 32'(mem_write), 0);
            chk("rst_mem_addr", mem_addr, 0);      chk("rst_mem_wdata", mem_wdata, 0);
            streak = 0; live = 0; in_rmw = 0; e_if_rv = 0; e_d_rv = 0; e_wack = 0;
        end else begin
            chk("if_rvalid", 32'(if_rvalid), 32'(e_if_rv));
            chk("d_rvalid", 32'(d_rvalid), 32'(e_d_rv));
            chk("d_wack", 32'(d_wack), 32'(e_wack));
            if (e_if_rv) chk("if_rdata", if_rdata, e_rdata);
            if (e_d_rv)  chk("d_rdata", d_rdata, e_rdata);
            gi = 0; gd = 0;
            if (live && !in_rmw) begin
                if (if_req && d_req) begin
                    if (streak == MAXD) gi = 1; else gd = 1;
                end else begin
                    gi = if_req; gd = d_req;
                end
            end
            chk("if_gnt", 32'(if_gnt), 32'(gi));
            chk("d_gnt", 32'(d_gnt), 32'(gd));
            n_if = 0; n_d = 0; n_wack = 0; n_rmw = 0; n_rdata = '0;
            if (in_rmw) begin
                chk("rmw_write", 32'(mem_write), 1);
                chk("rmw_addr", mem_addr, 32'(rmw_idx));
                chk("rmw_wdata", mem_wdata, rmw_val);
                ref_mem[rmw_idx] = rmw_val;
                n_wack = 1;
            end else if (gi) begin
                chk("if_mem_write", 32'(mem_write), 0);
                chk("if_mem_addr", mem_addr, 32'(widx(if_addr)));
                n_if = 1; n_rdata = ref_mem[widx(if_addr)];
            end else if (gd) begin
                chk("d_mem_addr", mem_addr, 32'(widx(d_addr)));
                if (!d_we) begin
                    chk("ld_mem_write", 32'(mem_write), 0);
                    n_d = 1; n_rdata = ref_mem[widx(d_addr)];
                end else if (d_be == 4'hF) begin
                    chk("st_mem_write", 32'(mem_write), 1);
                    chk("st_mem_wdata", mem_wdata, d_wdata);
                    ref_mem[widx(d_addr)] = d_wdata;
                    n_wack = 1;
                end else if (d_be == 4'h0) begin
                    chk("nobe_mem_write", 32'(mem_write), 0);
                    n_wack = 1;
                end else begin
                    chk("rmw_rd_write", 32'(mem_write), 0);
                    n_rmw = 1; rmw_idx = widx(d_addr);
                    rmw_val = merge(ref_mem[rmw_idx], d_wdata, d_be);
                end
            end else begin
                chk("idle_mem_write", 32'(mem_write), 0);
            end
            if (!if_req || gi) streak = 0;
            else if (gd && streak < MAXD) streak++;
            e_if_rv = n_if; e_d_rv = n_d; e_wack = n_wack; e_rdata = n_rdata;
            in_rmw = n_rmw; live = 1;
        end
        @(negedge clk);
    endtask

    logic [5:0] seq;

    initial begin
        checks = 0; errors = 0;
        rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_be = '0;
        d_addr = '0; d_wdata = '0;
        streak = 0; live = 0; in_rmw = 0; e_if_rv = 0; e_d_rv = 0; e_wack = 0;
        e_rdata = '0; rmw_idx = 0; rmw_val = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[0] = 32'h0200_0837; ref_mem[0] = 32'h0200_0837;
        @(negedge clk);
        cycle(); cycle();

        // First cycle after reset: no grant even with a request pending
        rst = 0; if_req = 1; if_addr = 32'h0;
        cycle();
        chk("post_rst_if_gnt", 32'(o_if_gnt), 0);

        // IF fetch of word 0
        cycle();
        chk("t1_if_gnt", 32'(o_if_gnt), 1);
        chk("t1_if_rdata", if_rdata, 32'h0200_0837);
        if_req = 0;

        // Both held: D,D,D,D,IF,D
        if_req = 1; if_addr = 32'h20; d_req = 1; d_we = 0; d_addr = 32'h8;
        for (int i = 0; i < 6; i++) begin
            cycle();
            seq = {seq[4:0], o_d_gnt};
        end
        chk("t2_grant_seq", 32'(seq), 32'b111101);
        if_req = 0; d_req = 0;

        // Full store then load
        d_req = 1; d_we = 1; d_be = 4'hF; d_addr = 32'h10; d_wdata = 32'hDEAD_BEEF;
        cycle();
        chk("t3_wack_n1", 32'(d_wack), 1);
        d_we = 0;
        cycle();
        chk("t3_load", d_rdata, 32'hDEAD_BEEF);
        d_req = 0;

        // Partial store with IF waiting: blocked during RMW_WR, wack at N+2
        d_req = 1; d_we = 1; d_be = 4'b0001; d_addr = 32'h10; d_wdata = 32'h0000_00AA;
        if_req = 1; if_addr = 32'h40;
        cycle();
        d_req = 0;
        cycle();
        chk("t4_rmw_if_blocked", 32'(o_if_gnt), 0);
        chk("t4_rmw_write", 32'(o_mem_write), 1);
        cycle();
        chk("t4_wack_n2", 32'(o_wack), 1);
        if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h10;
        cycle();
        chk("t4_reload", d_rdata, 32'hDEAD_BEAA);
        d_req = 0;

        // Reset during RMW_WR drops the write
        d_req = 1; d_we = 1; d_be = 4'b0010; d_addr = 32'h10; d_wdata = 32'h0000_1100;
        cycle();
        d_req = 0; rst = 1;
        cycle();
        chk("t5_no_write_in_rst", 32'(o_mem_write), 0);
        rst = 0;
        cycle();
        d_req = 1; d_we = 0; d_addr = 32'h10;
        cycle();
        chk("t5_word_kept", d_rdata, 32'hDEAD_BEAA);
        d_req = 0;

        // Address wrap and ignored low bits
        if_req = 1; if_addr = 32'h1004;
        cycle();
        chk("t6_wrap", o_mem_addr, 32'd1);
        if_addr = 32'h3;
        cycle();
        chk("t6_lowbits", o_mem_addr, 32'd0);
        if_req = 0;

        // Randomized traffic; requesters hold until granted
        for (int n = 0; n < 600; n++) begin
            if (!if_req && $urandom_range(0, 2) != 0) begin
                if_req = 1; if_addr = rand_addr();
            end
            if (!d_req && $urandom_range(0, 2) != 0) begin
                d_req = 1; d_we = 1'($urandom); d_addr = rand_addr(); d_wdata = $urandom;
                case ($urandom_range(0, 3))
                    0:       d_be = 4'hF;
                    1:       d_be = 4'h0;
                    default: d_be = 4'($urandom);
                endcase
            end
            cycle();
            if (o_if_gnt) if_req = 0;
            if (o_d_gnt)  d_req = 0;
        end
        if_req = 0; d_req = 0;
        cycle(); cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
